fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 24-bit ASIP pipeline. It owns the program counter, drives the instruction-memory address, and registers fetched words into the IF/ID pipeline register consumed by the decode stage of `microarchitecture`. It handles program-bank selection at reset, branch redirects with flush, hazard stalls, and a halt state entered on the HALT opcode.

## Interface
- `ADDR_W`, default 24: PC and instruction-memory address width.
- `INSTR_W`, default 24: instruction width.
- `PROG0_BASE`, default 24'h000000: reset PC when `sel`=0.
- `PROG1_BASE`, default 24'h000100: reset PC when `sel`=1.
- `HALT_OPC`, default 4'hF: opcode in `instr[23:20]` that halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sel`  in  1  program-bank select; sampled only while `reset`=1.
- `stall`  in  1  hazard stall from decode; holds PC and IF/ID.
- `branchControl`  in  1  taken branch/jump resolved in EX.
- `branchTarget`  in  ADDR_W  redirect address; valid when `branchControl`=1.
- `imem_addr`  out  ADDR_W  combinational copy of the PC register.
- `imem_rdata`  in  INSTR_W  instruction memory, asynchronous read of `imem_addr`.
- `PC`  out  ADDR_W  IF/ID: address of the word in `instruction`.
- `instruction`  out  INSTR_W  IF/ID: fetched word, or NOP (24'h000000) when invalid.
- `valid`  out  1  IF/ID word is real (not a bubble).
- `halted`  out  1  high while in HALTED.

## Operation
- State machine: RUN, HALTED. Reset enters RUN.
- Priority at each edge: `reset` > `branchControl` > `stall` > normal fetch.
- Reset: `pc_q` is set to PROG1_BASE if `sel`=1, else PROG0_BASE. `PC` is set to 0, `instruction` to NOP, `valid` to 0, `halted` to 0.
- Normal (RUN, no stall, no branch): `pc_q` advances to `pc_q`+1 (word-addressed; it wraps from 2^ADDR_W−1 to 0). IF/ID loads {`pc_q`, `imem_rdata`} and sets `valid` to 1.
- HALT fetch: in RUN, if `imem_rdata[23:20]`=HALT_OPC with no branch and no stall, the HALT word is loaded into IF/ID with `valid`=1. `pc_q` is not incremented and the state goes to HALTED.
- HALTED: `pc_q` is frozen. IF/ID loads NOP with `valid`=0 every cycle. `stall` is ignored.
- Branch (any state): `pc_q` is set to `branchTarget`. IF/ID is flushed (NOP, `valid`=0) and the state goes to RUN. A branch therefore cancels a speculatively fetched HALT.
- Stall (RUN, no branch): `pc_q`, IF/ID and the state all hold.
- `branchTarget` is ignored when `branchControl`=0.

## Timing
- Fetch-to-IF/ID latency is one cycle. The word addressed at edge N appears on `instruction` after edge N+1.
- The branch penalty is the one flushed IF/ID slot produced by this block. Any squashing of downstream stages belongs to those stages.
- First real instruction after reset deasserts: `valid`=1 one edge after the first edge with `reset`=0.
- Reset asserted mid-program: the next edge restores all reset values and re-samples `sel`. Any pending branch is discarded.
- Stall and branch in the same cycle: the branch wins, with no hold.
- `halted` is registered and equals (state==HALTED).

## Structure
- Shared package `asip_pkg`:
  - ADDR_W and INSTR_W widths.
  - NOP encoding.
  - HALT_OPC.
  - Opcode field slice constants.
  - The fetch state enum `fetch_state_t` {RUN, HALTED}.
- Sub-module `if_id_reg`: the pipeline register, with load, flush and hold controls and outputs `PC`, `instruction`, `valid`.
- `fetch_stage` contains the PC register, next-PC mux, FSM and `if_id_reg`.

## Test plan
- Reset with `sel`=1, memory linear with 24'h0000AA at 0x100: release reset → `imem_addr`=0x100. The next edge gives `PC`=0x100, `instruction`=24'h0000AA, `valid`=1; `imem_addr`=0x101.
- Reset with `sel`=0 after running bank 1 for 8 cycles: `imem_addr`=0x000 during reset. `valid`=0 and `instruction`=NOP during reset, and bank 0 is fetched afterwards.
- `stall` high for 3 cycles at PC=0x005: `imem_addr`, `PC` and `instruction` are unchanged for all 3 cycles. Fetch resumes at 0x006 with no lost or duplicated word.
- `branchControl`=1, `branchTarget`=0x040, with `stall`=1 in the same cycle: next `imem_addr`=0x040 and IF/ID=NOP with `valid`=0. The following edge gives `PC`=0x040 and `valid`=1.
- HALT word 24'hF00000 at 0x010: IF/ID shows `PC`=0x010 with the HALT word; `halted`=1 and `valid`=0 afterwards, with `imem_addr` frozen at 0x010. A branch to 0x020 while halted gives `halted`=0 and fetch resumes at 0x020.
- PC wrap: force `pc_q`=24'hFFFFFF via a reset bank parameter → the next `imem_addr` is 24'h000000 and the word at 24'hFFFFFF reaches IF/ID with `valid`=1.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared definitions for the 24-bit ASIP pipeline: widths, NOP, HALT opcode, fetch FSM states.
package asip_pkg;

    localparam int unsigned ASIP_ADDR_W  = 24;
    localparam int unsigned ASIP_INSTR_W = 24;

    localparam int unsigned OPC_MSB = 23;
    localparam int unsigned OPC_LSB = 20;

    localparam logic [ASIP_INSTR_W-1:0] NOP           = 24'h000000;
    localparam logic [3:0]              ASIP_HALT_OPC = 4'hF;

    typedef enum logic [0:0] {
        RUN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush insert a NOP bubble, load captures a fetch, else hold.
module if_id_reg
    import asip_pkg::*;
#(
    parameter int unsigned ADDR_W  = ASIP_ADDR_W,
    parameter int unsigned INSTR_W = ASIP_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            instr_d = INSTR_W'(NOP);
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= INSTR_W'(NOP);
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/HALTED FSM and the IF/ID register.
module fetch_stage
    import asip_pkg::*;
#(
    parameter int unsigned        ADDR_W     = ASIP_ADDR_W,
    parameter int unsigned        INSTR_W    = ASIP_INSTR_W,
    parameter logic [ADDR_W-1:0]  PROG0_BASE = ADDR_W'(24'h000000),
    parameter logic [ADDR_W-1:0]  PROG1_BASE = ADDR_W'(24'h000100),
    parameter logic [3:0]         HALT_OPC   = ASIP_HALT_OPC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sel,
    input  logic               stall,
    input  logic               branchControl,
    input  logic [ADDR_W-1:0]  branchTarget,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid,
    output logic               halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ifid_load, ifid_flush;
    logic              is_halt;

    assign is_halt = (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPC);

    // Branch beats everything (including a fetched HALT); HALTED ignores stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (branchControl) begin
            pc_d       = branchTarget;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else if (state_q == HALTED) begin
            ifid_flush = 1'b1;
        end else if (!stall) begin
            ifid_load = 1'b1;
            if (is_halt) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= sel ? PROG1_BASE : PROG0_BASE;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_if_id_reg (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (ifid_load),
        .flush_i(ifid_flush),
        .pc_i   (pc_q),
        .instr_i(imem_rdata),
        .pc_o   (PC),
        .instr_o(instruction),
        .valid_o(valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, sel, stall, branchControl;
    logic [23:0] branchTarget, imem_addr, imem_rdata, PC, instruction;
    logic        valid, halted;

    logic        w_reset;
    logic [23:0] w_addr, w_rdata, w_pc, w_instr;
    logic        w_valid, w_halted;

    logic [23:0] mem [512];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model of the fetch stage
    logic [23:0] m_pc, m_ifpc, m_ifins;
    logic        m_ifv, m_halted;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[8:0]];
    assign w_rdata    = (w_addr == 24'hFFFFFF) ? 24'h123456 : (w_addr & 24'h0FFFFF);

    fetch_stage u_dut (
        .clk          (clk),
        .reset        (reset),
        .sel          (sel),
        .stall        (stall),
        .branchControl(branchControl),
        .branchTarget (branchTarget),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .instruction  (instruction),
        .valid        (valid),
        .halted       (halted)
    );

    fetch_stage #(
        .PROG1_BASE(24'hFFFFFF)
    ) u_wrap (
        .clk          (clk),
        .reset        (w_reset),
        .sel          (1'b1),
        .stall        (1'b0),
        .branchControl(1'b0),
        .branchTarget (24'h000000),
        .imem_addr    (w_addr),
        .imem_rdata   (w_rdata),
        .PC           (w_pc),
        .instruction  (w_instr),
        .valid        (w_valid),
        .halted       (w_halted)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc     <= sel ? 24'h000100 : 24'h000000;
            m_halted <= 1'b0;
            m_ifpc   <= 24'h0;
            m_ifins  <= 24'h0;
            m_ifv    <= 1'b0;
        end else if (branchControl) begin
            m_pc     <= branchTarget;
            m_halted <= 1'b0;
            m_ifins  <= 24'h0;
            m_ifv    <= 1'b0;
        end else if (m_halted) begin
            m_ifins <= 24'h0;
            m_ifv   <= 1'b0;
        end else if (!stall) begin
            m_ifpc  <= m_pc;
            m_ifins <= mem[m_pc[8:0]];
            m_ifv   <= 1'b1;
            if (mem[m_pc[8:0]][23:20] == 4'hF) m_halted <= 1'b1;
            else                               m_pc     <= m_pc + 24'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model imem_addr", imem_addr, m_pc);
            check("model valid", valid, m_ifv);
            check("model instruction", instruction, m_ifins);
            check("model halted", halted, m_halted);
            if (m_ifv) check("model PC", PC, m_ifpc);
        end
    end

    // PC wrap through a bank base at the top of the address space
    initial begin
        w_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("wrap reset addr", w_addr, 24'hFFFFFF);
        w_reset = 1'b0;
        @(negedge clk);
        check("wrap next addr", w_addr, 24'h000000);
        check("wrap PC", w_pc, 24'hFFFFFF);
        check("wrap instr", w_instr, 24'h123456);
        check("wrap valid", w_valid, 1'b1);
    end

    initial begin
        int k;
        for (int i = 0; i < 512; i++) mem[i] = 24'(i);
        mem[9'h100] = 24'h0000AA;
        reset = 1'b1; sel = 1'b1; stall = 1'b0; branchControl = 1'b0; branchTarget = 24'h0;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("bank1 reset addr", imem_addr, 24'h000100);
        check("reset valid", valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("bank1 first PC", PC, 24'h000100);
        check("bank1 first instr", instruction, 24'h0000AA);
        check("bank1 first valid", valid, 1'b1);
        check("bank1 next addr", imem_addr, 24'h000101);
        repeat (7) @(negedge clk);

        reset = 1'b1; sel = 1'b0;
        @(negedge clk);
        check("bank0 reset addr", imem_addr, 24'h000000);
        check("bank0 reset valid", valid, 1'b0);
        check("bank0 reset instr", instruction, 24'h000000);
        reset = 1'b0;

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (imem_addr != 24'h000005 && k < 20);
        check("reach pc 5", imem_addr, 24'h000005);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall addr", imem_addr, 24'h000005);
            check("stall PC", PC, 24'h000004);
            check("stall instr", instruction, 24'h000004);
        end
        stall = 1'b0;
        @(negedge clk);
        check("resume PC", PC, 24'h000005);
        check("resume addr", imem_addr, 24'h000006);
        @(negedge clk);
        check("resume PC+1", PC, 24'h000006);

        branchControl = 1'b1; branchTarget = 24'h000040; stall = 1'b1;
        @(negedge clk);
        check("branch addr", imem_addr, 24'h000040);
        check("branch flush valid", valid, 1'b0);
        check("branch flush instr", instruction, 24'h000000);
        branchControl = 1'b0; stall = 1'b0; branchTarget = 24'hABCDEF;
        @(negedge clk);
        check("branch target PC", PC, 24'h000040);
        check("branch target valid", valid, 1'b1);

        mem[9'h010] = 24'hF00000;
        branchControl = 1'b1; branchTarget = 24'h000010;
        @(negedge clk);
        branchControl = 1'b0;
        @(negedge clk);
        check("halt PC", PC, 24'h000010);
        check("halt instr", instruction, 24'hF00000);
        check("halt valid", valid, 1'b1);
        check("halt flag", halted, 1'b1);
        stall = 1'b1;
        @(negedge clk);
        check("halted valid", valid, 1'b0);
        check("halted frozen addr", imem_addr, 24'h000010);
        stall = 1'b0;
        branchControl = 1'b1; branchTarget = 24'h000020;
        @(negedge clk);
        check("unhalt flag", halted, 1'b0);
        check("unhalt addr", imem_addr, 24'h000020);
        branchControl = 1'b0;
        @(negedge clk);
        check("unhalt PC", PC, 24'h000020);
        check("unhalt valid", valid, 1'b1);
        mem[9'h010] = 24'h000010;

        for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset         = ($urandom_range(99) == 0);
            sel           = 1'($urandom_range(1));
            stall         = ($urandom_range(3) == 0);
            branchControl = ($urandom_range(7) == 0);
            branchTarget  = ($urandom_range(1) == 0) ? 24'($urandom_range(511)) : 24'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; branchControl = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
